ps2_command_tx: RTL and testbench
=================================

# ps2_command_tx

Host-to-device PS/2 command transmitter: drives the open-drain PS2_CLK/PS2_DAT lines to send one 8-bit command byte to the mouse (e.g. 0xF4 "enable data reporting", 0xFF "reset"), and checks the device acknowledge. It sits beside the mouse receive path on the same two bus lines. It holds `busy` high while it owns the bus so that the receiver ignores the bus for that time.

## Interface
- INHIBIT_CYCLES, 5000: clock cycles PS2_CLK is held low before the start bit (100 us at 50 MHz).
- REQUEST_CYCLES, 2: cycles PS2_CLK and PS2_DAT are both held low before PS2_CLK is released.
- TIMEOUT_CYCLES, 750000: maximum cycles allowed between device clock falling edges (15 ms at 50 MHz).

- clock  input  1  system clock; all logic on its rising edge.
- reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
- send_command  input  1  request strobe; sampled only in IDLE.
- command  input  8  byte to send; captured on the cycle send_command is accepted.
- PS2_CLK  inout  1  open-drain: driven 0 or left at high-Z, never driven 1.
- PS2_DAT  inout  1  open-drain: driven 0 or left at high-Z, never driven 1.
- busy  output  1  high from the cycle after acceptance until the cycle of the done/error pulse, inclusive.
- command_sent  output  1  one-cycle pulse: byte sent and ACK seen.
- error  output  1  one-cycle pulse: timeout or missing ACK.

## Operation
- PS2_CLK and PS2_DAT each pass through a 2-flop synchronizer. A falling edge is a synchronized 1 followed by a synchronized 0, using one extra history flop.
- Frame register (10 bits, LSB first): D0..D7, parity = ~^command (odd parity), stop = 1.
- States:
  - IDLE: both lines released. send_command=1 → capture the frame, clear the counters → INHIBIT.
  - INHIBIT: drive PS2_CLK low, release PS2_DAT, for INHIBIT_CYCLES cycles → REQUEST.
  - REQUEST: drive PS2_CLK low and PS2_DAT low (start bit) for REQUEST_CYCLES cycles → TX.
  - TX: release PS2_CLK. PS2_DAT outputs the current bit, where 0 drives low and 1 releases.
    - Start bit is held until falling edge 1.
    - Falling edges 1–9 present D0..D7 and then parity.
    - Falling edge 10 presents stop, which releases the line → ACK.
  - ACK: both lines released. On the next falling edge (edge 11), sample synchronized PS2_DAT: 0 → WAIT_IDLE with ok flag set; 1 → WAIT_IDLE with ok flag cleared.
  - WAIT_IDLE: wait until both synchronized lines are 1. Then pulse command_sent (ok) or error (not ok) → IDLE.
- Timeout: a cycle counter runs in TX, ACK and WAIT_IDLE and clears on every falling edge. When it reaches TIMEOUT_CYCLES: release both lines, pulse error, go to IDLE.
- Bit counter is 4 bits; the timeout counter is wide enough for TIMEOUT_CYCLES. Neither wraps; both saturate or are cleared by a state change.
- send_command outside IDLE is ignored, not queued. command is not sampled after acceptance.

## Timing
- Reset values: state IDLE, both lines high-Z, busy=0, command_sent=0, error=0, all counters 0.
- Reset asserted mid-frame releases both lines asynchronously, in the same instant, and abandons the frame with no pulse.
- Accept at cycle T: busy=1 and PS2_CLK low from T+1.
- PS2_DAT goes low at T+1+INHIBIT_CYCLES. PS2_CLK is released at T+1+INHIBIT_CYCLES+REQUEST_CYCLES.
- Data change latency: PS2_DAT updates within 3 cycles of a raw PS2_CLK falling edge (2 synchronizer cycles + 1 register).
- command_sent/error is high for exactly one cycle. busy drops the cycle after the pulse, and IDLE can accept a new request on that same cycle.
- Falling edges seen during INHIBIT or REQUEST are ignored.

## Test plan
- Bench setup for all scenarios: INHIBIT_CYCLES=20, TIMEOUT_CYCLES=400, device model clocking at a 40-cycle period.
- command=0xF4: PS2_CLK low for 20 cycles, then start bit. The device samples on rising edges and must read 0,0,1,0,1,1,1,1, parity 0, stop 1. Device ACK=0 → one command_sent pulse, error stays 0, busy 0 afterward.
- command=0xFF → data bits all 1, parity 1. Device leaves PS2_DAT high at edge 11 → error pulse, no command_sent.
- Device stops clocking after edge 4 → error exactly 400 cycles after edge 4; both lines released; busy=0.
- Assert reset low in the middle of TX at bit 5 → lines high-Z immediately, no pulse. After release, command=0xF4 completes normally.
- Pulse send_command with 0x00 while busy with 0xF4 → only 0xF4 is transmitted (parity 0). Exactly one command_sent pulse.

Source files
------------

// File: rtl/ps2_command_tx.sv
// Host-to-device PS/2 command transmitter.
// Drives the open-drain PS2_CLK/PS2_DAT lines to send one command byte
// (LSB first, odd parity, stop bit), then checks the device ACK bit.
// busy is held high while the bus is owned so the receive path ignores it.
module ps2_command_tx #(
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned REQUEST_CYCLES = 2,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       send_command,
  input  logic [7:0] command,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DAT,
  output logic       busy,
  output logic       command_sent,
  output logic       error
);

  localparam int unsigned DLY_MAX = (INHIBIT_CYCLES > REQUEST_CYCLES) ? INHIBIT_CYCLES
                                                                      : REQUEST_CYCLES;
  localparam int unsigned DLY_W   = $clog2(DLY_MAX + 1);
  localparam int unsigned TO_W    = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_REQUEST,
    S_TX,
    S_ACK,
    S_WAIT_IDLE
  } state_t;

  state_t           state;
  logic             clk_s1, clk_s2, clk_s3;
  logic             dat_s1, dat_s2;
  logic             clk_fall;
  logic             timed_out;
  logic [9:0]       frame;
  logic [3:0]       bit_cnt;
  logic [DLY_W-1:0] dly_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             clk_oe;
  logic             dat_oe;
  logic             ack_ok;

  // Open-drain drivers: only ever pull low or release.
  assign PS2_CLK = clk_oe ? 1'b0 : 1'bz;
  assign PS2_DAT = dat_oe ? 1'b0 : 1'bz;

  // Two-flop synchronizers plus one history flop on the clock line for edge detection.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_s3 <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= PS2_CLK;
      clk_s2 <= clk_s1;
      clk_s3 <= clk_s2;
      dat_s1 <= PS2_DAT;
      dat_s2 <= dat_s1;
    end
  end

  assign clk_fall  = clk_s3 & ~clk_s2;
  // A falling edge on the same cycle rescues the frame from timing out.
  assign timed_out = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) && !clk_fall;

  // Transmit sequencer with registered line enables and status pulses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      frame        <= '0;
      bit_cnt      <= '0;
      dly_cnt      <= '0;
      to_cnt       <= '0;
      clk_oe       <= 1'b0;
      dat_oe       <= 1'b0;
      ack_ok       <= 1'b0;
      busy         <= 1'b0;
      command_sent <= 1'b0;
      error        <= 1'b0;
    end else begin
      command_sent <= 1'b0;
      error        <= 1'b0;
      case (state)
        S_IDLE: begin
          clk_oe <= 1'b0;
          dat_oe <= 1'b0;
          busy   <= send_command;
          if (send_command) begin
            frame   <= {1'b1, ~^command, command};
            bit_cnt <= '0;
            dly_cnt <= '0;
            to_cnt  <= '0;
            ack_ok  <= 1'b0;
            clk_oe  <= 1'b1;
            state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (dly_cnt == DLY_W'(INHIBIT_CYCLES - 1)) begin
            dly_cnt <= '0;
            dat_oe  <= 1'b1;
            state   <= S_REQUEST;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_REQUEST: begin
          if (dly_cnt == DLY_W'(REQUEST_CYCLES - 1)) begin
            dly_cnt <= '0;
            clk_oe  <= 1'b0;
            state   <= S_TX;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        default: begin
          // TX, ACK and WAIT_IDLE share the inter-edge timeout watchdog.
          if (timed_out) begin
            clk_oe <= 1'b0;
            dat_oe <= 1'b0;
            error  <= 1'b1;
            state  <= S_IDLE;
          end else begin
            to_cnt <= clk_fall ? '0 : to_cnt + 1'b1;
            case (state)
              S_TX: begin
                if (clk_fall) begin
                  dat_oe  <= ~frame[bit_cnt];
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 4'd9) state <= S_ACK;
                end
              end
              S_ACK: begin
                if (clk_fall) begin
                  ack_ok <= ~dat_s2;
                  state  <= S_WAIT_IDLE;
                end
              end
              S_WAIT_IDLE: begin
                if (clk_s2 && dat_s2) begin
                  command_sent <= ack_ok;
                  error        <= ~ack_ok;
                  state        <= S_IDLE;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_command_tx.sv
// Self-checking bench for ps2_command_tx with a behavioural PS/2 device model.
module tb_ps2_command_tx;

  localparam int unsigned INH = 20;
  localparam int unsigned REQ = 2;
  localparam int unsigned TMO = 400;

  logic       clock        = 1'b0;
  logic       reset        = 1'b0;
  logic       send_command = 1'b0;
  logic [7:0] command      = '0;
  logic       busy;
  logic       command_sent;
  logic       error;
  wire        ps2_clk;
  wire        ps2_dat;

  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;

  int n_cmp    = 0;
  int n_bad    = 0;
  int cyc      = 0;
  int fall_cyc = 0;

  // Expected status pulses {command_sent, error} and expected 10-bit frames.
  logic [1:0] exp_evt[$];
  logic [9:0] exp_frame[$];

  pullup (ps2_clk);
  pullup (ps2_dat);
  assign ps2_clk = dev_clk_low ? 1'b0 : 1'bz;
  assign ps2_dat = dev_dat_low ? 1'b0 : 1'bz;

  ps2_command_tx #(
    .INHIBIT_CYCLES(INH),
    .REQUEST_CYCLES(REQ),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .send_command(send_command),
    .command     (command),
    .PS2_CLK     (ps2_clk),
    .PS2_DAT     (ps2_dat),
    .busy        (busy),
    .command_sent(command_sent),
    .error       (error)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every cycle a status pulse is high consumes one expected event.
  always @(negedge clock) begin
    if (reset && (command_sent || error)) begin
      if (exp_evt.size() == 0) check("unexpected_pulse", {30'b0, command_sent, error}, 32'h0);
      else                     check("status_pulse", {30'b0, command_sent, error},
                                     {30'b0, exp_evt.pop_front()});
    end
  end

  task automatic send(input logic [7:0] cmd);
    @(negedge clock);
    send_command = 1'b1;
    command      = cmd;
    @(negedge clock);
    send_command = 1'b0;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!(ps2_clk === 1'b1 && ps2_dat === 1'b0) && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("start_bit_seen", {31'b0, n < 200}, 32'h1);
  endtask

  task automatic wait_not_busy();
    int n = 0;
    while (busy !== 1'b0 && n < 200) begin
      @(negedge clock);
      n++;
    end
    check("busy_release", {31'b0, busy}, 32'h0);
  endtask

  // Device model: 40-cycle bus clock, samples data on rising edges, optional ACK.
  task automatic device_run(input int n_edges, input bit give_ack);
    logic [9:0] got = '0;
    for (int i = 1; i <= n_edges; i++) begin
      if (i == 11 && give_ack) dev_dat_low = 1'b1;
      repeat (20) @(negedge clock);
      dev_clk_low = 1'b1;
      fall_cyc    = cyc;
      repeat (20) @(negedge clock);
      dev_clk_low = 1'b0;
      if (i <= 10) got[i-1] = ps2_dat;
    end
    if (give_ack) begin
      repeat (5) @(negedge clock);
      dev_dat_low = 1'b0;
    end
    if (n_edges >= 10) begin
      if (exp_frame.size() == 0) check("unexpected_frame", {22'b0, got}, 32'h0);
      else                       check("frame_bits", {22'b0, got}, {22'b0, exp_frame.pop_front()});
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n;

    // Reset state
    repeat (3) @(negedge clock);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_sent", {31'b0, command_sent}, 32'h0);
    check("rst_error", {31'b0, error}, 32'h0);
    check("rst_clk_released", {31'b0, ps2_clk}, 32'h1);
    check("rst_dat_released", {31'b0, ps2_dat}, 32'h1);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // 0xF4 with ACK: inhibit/request timing, frame bits, command_sent
    exp_evt.push_back(2'b10);
    exp_frame.push_back(10'h2F4);
    send(8'hF4);
    check("busy_after_accept", {31'b0, busy}, 32'h1);
    n = 0;
    while (ps2_clk === 1'b0 && ps2_dat === 1'b1 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("inhibit_cycles", n, INH);
    n = 0;
    while (ps2_clk === 1'b0 && ps2_dat === 1'b0 && n < 100) begin
      n++;
      @(negedge clock);
    end
    check("request_cycles", n, REQ);
    check("start_clk_released", {31'b0, ps2_clk}, 32'h1);
    check("start_dat_low", {31'b0, ps2_dat}, 32'h0);
    device_run(11, 1'b1);
    wait_not_busy();
    check("f4_events_done", exp_evt.size(), 0);

    // 0xFF without ACK: all-ones data, parity 1, error pulse
    exp_evt.push_back(2'b01);
    exp_frame.push_back(10'h3FF);
    send(8'hFF);
    wait_start();
    device_run(11, 1'b0);
    wait_not_busy();
    check("ff_events_done", exp_evt.size(), 0);

    // Device stops after edge 4: timeout 400 cycles after detection (+3 sync/register)
    exp_evt.push_back(2'b01);
    send(8'hF4);
    wait_start();
    device_run(4, 1'b0);
    n = 0;
    while (error !== 1'b1 && n < 600) begin
      @(negedge clock);
      n++;
    end
    check("timeout_latency", cyc - fall_cyc, TMO + 3);
    @(negedge clock);
    check("timeout_busy", {31'b0, busy}, 32'h0);
    check("timeout_clk_released", {31'b0, ps2_clk}, 32'h1);
    check("timeout_dat_released", {31'b0, ps2_dat}, 32'h0 + 1);

    // Reset mid-TX while the host drives a 0 data bit
    send(8'h00);
    wait_start();
    device_run(5, 1'b0);
    @(negedge clock);
    check("pre_reset_dat_low", {31'b0, ps2_dat}, 32'h0);
    reset = 1'b0;
    #1;
    check("reset_clk_released", {31'b0, ps2_clk}, 32'h1);
    check("reset_dat_released", {31'b0, ps2_dat}, 32'h1);
    check("reset_busy", {31'b0, busy}, 32'h0);
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    exp_evt.push_back(2'b10);
    exp_frame.push_back(10'h2F4);
    send(8'hF4);
    wait_start();
    device_run(11, 1'b1);
    wait_not_busy();

    // Request while busy is ignored; command changes after acceptance are ignored
    exp_evt.push_back(2'b10);
    exp_frame.push_back(10'h2F4);
    send(8'hF4);
    repeat (5) @(negedge clock);
    send_command = 1'b1;
    command      = 8'h00;
    @(negedge clock);
    send_command = 1'b0;
    check("busy_during_ignored_req", {31'b0, busy}, 32'h1);
    wait_start();
    device_run(11, 1'b1);
    wait_not_busy();
    repeat (50) @(negedge clock);
    check("pending_events", exp_evt.size(), 0);
    check("pending_frames", exp_frame.size(), 0);
    check("idle_busy", {31'b0, busy}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
